// File: rtl/mbv_result_collector.sv
// Reassembles U-element result beats from the matrix-by-vector engine into one N-element vector.
// Optional MBV_COLLECTOR_CLEAR_EN: zero the vector when a new collection starts.
module mbv_result_collector #(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width = 32,
  parameter int no_of_units = 4,
  localparam int beats = (no_of_eqn_per_cluster + no_of_units - 1) / no_of_units,
  localparam int cnt_w = $clog2(beats + 1)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           in_valid,
  input  logic [no_of_units*element_width-1:0]           in_data,
  output logic [no_of_eqn_per_cluster*element_width-1:0] out_full,
  output logic [cnt_w-1:0]                               beat_cnt,
  output logic                                           finish,
  output logic                                           extra_beat,
  output logic [1:0]                                     state_dbg
);
  localparam int n_el = no_of_eqn_per_cluster;
  localparam int ew   = element_width;
  localparam int u    = no_of_units;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nx;
  logic accept, last_beat;
  logic [n_el*ew-1:0] vec_nx;

  // A beat is taken only with start high and never once the vector is complete.
  assign accept    = start && in_valid && (state != DONE);
  assign last_beat = accept && (beat_cnt == cnt_w'(beats - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!start) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = last_beat ? DONE : COLLECT;
        COLLECT: if (last_beat) state_nx = DONE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    finish    = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt   <= '0;
      extra_beat <= 1'b0;
    end else if (!start) begin
      beat_cnt   <= '0;
      extra_beat <= 1'b0;
    end else begin
      if (accept) beat_cnt <= beat_cnt + cnt_w'(1);
      if (state == DONE && in_valid) extra_beat <= 1'b1;
    end
  end

  // Element i belongs to beat i/u at lane i%u; padding lanes have no destination.
  always_comb begin
    vec_nx = out_full;
`ifdef MBV_COLLECTOR_CLEAR_EN
    if (state == IDLE && start) vec_nx = '0;
`endif
    for (int i = 0; i < n_el; i++) begin
      if (accept && (int'(beat_cnt) == i / u))
        vec_nx[n_el*ew-1-i*ew -: ew] = in_data[u*ew-1-(i%u)*ew -: ew];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_full <= '0;
    else        out_full <= vec_nx;
  end
endmodule

// File: doc/mbv_result_collector.md
# mbv_result_collector

Receiving end of the matrix-by-vector result stream. Accepts `no_of_units` result elements per beat from the matrix-by-vector engine and reassembles them into one full result vector of `no_of_eqn_per_cluster` elements. It strips the padding elements of the final beat and raises `finish` when the vector is complete. It sits between the matrix-by-vector engine and the Jacobi update/convergence logic of a cluster.

## Interface
- `no_of_eqn_per_cluster`, 10, number of valid result elements (N).
- `element_width`, 32, bits per element.
- `no_of_units`, 4, elements per input beat (U).
- `beats`, derived, (N+U-1)/U. Beats per vector.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `start` input 1: level enable. Collection runs while high; low returns the block to idle.
- `in_valid` input 1: `in_data` carries a beat this cycle.
- `in_data` input U*element_width: beat elements. Lowest-index element is in the MSB slice.
- `out_full` output N*element_width: assembled vector. Element 0 is in the MSB slice `[N*ew-1 -: ew]`.
- `beat_cnt` output $clog2(beats+1): beats accepted so far.
- `finish` output 1: vector complete. Held until `start` drops.
- `extra_beat` output 1: sticky flag; a beat arrived while in DONE.

## Operation
- **States:** IDLE, COLLECT, DONE.
- **IDLE:**
  - `start`=1 moves to COLLECT on the next edge.
  - If `in_valid`=1 in that same cycle, the beat is accepted as beat 0.
  - `in_valid` is ignored while `start`=0.
- **COLLECT:** each `in_valid`=1 cycle writes beat k (k=`beat_cnt`).
  - Element j of the beat goes to vector index k*U+j, for j=0..U-1, with index < N.
  - Indices >= N (padding) are discarded.
  - `beat_cnt` increments.
- **Last beat:** acceptance of beat k=beats-1 moves the block to DONE and sets `finish`.
- **DONE:**
  - `out_full` is frozen.
  - `in_valid`=1 sets `extra_beat` and changes nothing else.
- **`start`=0 in any state:** synchronous return to IDLE.
  - `finish`, `beat_cnt` and `extra_beat` clear.
  - `out_full` keeps its contents (subject to Configuration).
- **Gaps:** `in_valid` gaps of any length within COLLECT are allowed. No timeout.
- **Arithmetic:** none. Data passes through bit-exact with no width change.

## Timing
- **Reset values:** all outputs 0 while `reset`=0, regardless of `clk`. State is IDLE.
- **Reset mid-collection:** the partial vector is lost and `out_full` reads 0.
- **Write latency:** a beat sampled at edge t is visible on `out_full` and `beat_cnt` after edge t.
- **`finish` latency:** rises after the same edge that accepts the last beat. It is not delayed a further cycle.
- **Minimum collection time:** `beats` cycles with `in_valid` held high.
- **Back-to-back vectors:** `start` must be low for at least 1 cycle between vectors.
- **Simultaneous events:**
  - `start`=0 with `in_valid`=1: `start` wins and the beat is dropped.
  - Last beat together with `start` falling: the beat is dropped and `finish` stays 0.
- **Exact fit:** when N%U==0 the last beat has no padding and all U elements are stored.

## Configuration
- **`MBV_COLLECTOR_CLEAR_EN` defined:** `out_full` is cleared to 0 on the IDLE->COLLECT edge.
  - If beat 0 is accepted on that edge, its elements are written and all other elements read 0.
  - Stale elements from the previous vector are never visible during collection.
- **`MBV_COLLECTOR_CLEAR_EN` not defined:** no clear. Elements not yet written keep their previous-vector values until overwritten.

## Test plan
- **Basic vector, N=10, U=4:** 3 back-to-back beats carrying elements 1..12.
  - `out_full` holds elements 1..10 (element 1 in the MSB slice), with 11 and 12 discarded.
  - `beat_cnt`=3; `finish`=1 after the 3rd edge.
- **Gapped input:** the same 3 beats with 2 idle cycles between each.
  - Result identical to the basic vector; `finish` rises after the edge accepting beat 3.
- **Extra beat:** a 4th beat of value 0xDEADBEEF after `finish`.
  - `extra_beat`=1 and `out_full` unchanged.
  - `start`=0 for 1 cycle clears `finish`, `beat_cnt` and `extra_beat`.
- **Reset mid-collection:** `reset`=0 asynchronously after beat 1.
  - All outputs read 0 immediately, without a clock edge.
  - After release, a new 3-beat vector assembles correctly.
- **Exact fit, N=8, U=4:** 2 beats of values 0x10..0x17.
  - All 8 elements are stored and `finish` rises after beat 2.
- **Clear option:** second vector, first beat carrying 0xA..0xD.
  - With `MBV_COLLECTOR_CLEAR_EN`: elements 4..9 read 0.
  - Without it: elements 4..9 keep the first vector's values.
